// File: rtl/qram_link_pkg.sv
// Shared definitions for both ends of the QRAM serial DDR link:
// FSM states, command encoding and default frame geometry.
package qram_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_TURN,
        ST_RDATA
    } qram_state_e;

    localparam logic QRAM_CMD_WRITE = 1'b1;
    localparam logic QRAM_CMD_READ  = 1'b0;

    localparam int QRAM_ADDR_W = 4;
    localparam int QRAM_DATA_W = 8;

    // Frame lengths in DDR edges (read adds one turnaround and one closing edge)
    localparam int QRAM_WR_FRAME_EDGES = 1 + QRAM_ADDR_W + QRAM_DATA_W;
    localparam int QRAM_RD_FRAME_EDGES = 1 + QRAM_ADDR_W + 1 + QRAM_DATA_W + 1;

endpackage

// File: rtl/qram_ddr_responder_if.sv
// Link-side signal bundle of the QRAM serial DDR link.
interface qram_ddr_responder_if;
    logic QRAM_DDRClockP;
    logic QRAM_DDRClockN;
    logic WritingToQBit;
    logic QBitToWrite;
    logic QBitToRead;
    logic ReadValid;
    logic Busy;
    logic FrameError;

    modport master (
        output QRAM_DDRClockP, QRAM_DDRClockN, WritingToQBit, QBitToWrite,
        input  QBitToRead, ReadValid, Busy, FrameError
    );

    modport slave (
        input  QRAM_DDRClockP, QRAM_DDRClockN, WritingToQBit, QBitToWrite,
        output QBitToRead, ReadValid, Busy, FrameError
    );
endinterface

// File: rtl/qram_ddr_edge_detect.sv
// Recovers DDR edges from an asynchronous differential clock pair as
// one-cycle strobes in the local clock domain; flags invalid (P == N) pairs.
module qram_ddr_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic ddr_p,
    input  logic ddr_n,
    output logic edge_stb,
    output logic invalid
);

    logic [1:0] p_sync;
    logic [1:0] n_sync;
    logic       p_prev;
    logic       compl;

    assign compl = p_sync[1] ^ n_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_sync   <= '0;
            n_sync   <= '0;
            p_prev   <= 1'b0;
            edge_stb <= 1'b0;
            invalid  <= 1'b0;
        end else begin
            p_sync   <= {p_sync[0], ddr_p};
            n_sync   <= {n_sync[0], ddr_n};
            edge_stb <= compl & (p_sync[1] ^ p_prev);
            invalid  <= ~compl;
            // Only a valid differential state updates the reference level
            if (compl)
                p_prev <= p_sync[1];
        end
    end

endmodule

// File: rtl/qram_ddr_responder.sv
// Memory-side responder of the QRAM DDR link: decodes read/write frames
// into a register array and serialises read data back to the initiator.
module qram_ddr_responder
    import qram_link_pkg::*;
#(
    parameter int ADDR_W = QRAM_ADDR_W,
    parameter int DATA_W = QRAM_DATA_W
) (
    input  logic                Clock,
    input  logic                ResetN,
    qram_ddr_responder_if.slave link
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    logic [1:0] rst_sync;
    logic       rst_n;

    // Reset asserts asynchronously, releases two clocks after ResetN rises
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) rst_sync <= '0;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic edge_stb;
    logic invalid;

    qram_ddr_edge_detect u_edge (
        .clk      (Clock),
        .rst_n    (rst_n),
        .ddr_p    (link.QRAM_DDRClockP),
        .ddr_n    (link.QRAM_DDRClockN),
        .edge_stb (edge_stb),
        .invalid  (invalid)
    );

    // Extra stage on the data bit lines it up with the registered edge strobe
    logic [1:0] we_sync;
    logic [1:0] dat_sync;
    logic       we_d;
    logic       dat_d;

    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            we_sync  <= '0;
            dat_sync <= '0;
            we_d     <= 1'b0;
            dat_d    <= 1'b0;
        end else begin
            we_sync  <= {we_sync[0], link.WritingToQBit};
            dat_sync <= {dat_sync[0], link.QBitToWrite};
            we_d     <= we_sync[1];
            dat_d    <= dat_sync[1];
        end
    end

    logic we_rise;
    logic we_fall;
    assign we_rise = we_sync[1] & ~we_d;
    assign we_fall = ~we_sync[1] & we_d;

    qram_state_e                   state;
    logic                          is_wr;
    logic [ADDR_W-1:0]             addr;
    logic [DATA_W-1:0]             wdata;
    logic [DATA_W-1:0]             rshift;
    logic [CNT_W-1:0]              cnt;
    logic [DEPTH-1:0][DATA_W-1:0]  mem;
    logic                          q_bit;
    logic                          read_valid;
    logic                          busy;
    logic                          frame_error;

    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            is_wr       <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            rshift      <= '0;
            cnt         <= '0;
            mem         <= '0;
            q_bit       <= 1'b0;
            read_valid  <= 1'b0;
            busy        <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (state != ST_IDLE && (we_fall || invalid)) begin
                frame_error <= 1'b1;
                state       <= ST_IDLE;
                busy        <= 1'b0;
                read_valid  <= 1'b0;
                q_bit       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (we_rise) begin
                        state <= ST_CMD;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                    ST_CMD: if (edge_stb) begin
                        is_wr <= dat_d;
                        cnt   <= '0;
                        state <= ST_ADDR;
                    end
                    ST_ADDR: if (edge_stb) begin
                        addr <= {addr[ADDR_W-2:0], dat_d};
                        if (cnt == CNT_W'(ADDR_W - 1)) begin
                            cnt   <= '0;
                            state <= (is_wr == QRAM_CMD_WRITE) ? ST_WDATA : ST_TURN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_WDATA: if (edge_stb) begin
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            mem[addr] <= {wdata[DATA_W-2:0], dat_d};
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            wdata <= {wdata[DATA_W-2:0], dat_d};
                            cnt   <= cnt + 1'b1;
                        end
                    end
                    // Snapshot taken here, so a read is never torn by a later write
                    ST_TURN: if (edge_stb) begin
                        rshift <= mem[addr];
                        cnt    <= '0;
                        state  <= ST_RDATA;
                    end
                    ST_RDATA: if (edge_stb) begin
                        if (cnt == CNT_W'(DATA_W)) begin
                            read_valid <= 1'b0;
                            q_bit      <= 1'b0;
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            q_bit      <= rshift[DATA_W-1];
                            rshift     <= {rshift[DATA_W-2:0], 1'b0};
                            read_valid <= 1'b1;
                            cnt        <= cnt + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign link.QBitToRead = q_bit;
    assign link.ReadValid  = read_valid;
    assign link.Busy       = busy;
    assign link.FrameError = frame_error;

endmodule
